// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_pkg
//  Description : Shared types and helpers for the parallel-in/serial-out
//                transmitter: FSM state encoding, default word width and the
//                bit-counter width function.
//  Revision    : 1.0  - initial release
// ============================================================================
package piso_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_SIZE = 4;

    // Counter holds (remaining bits - 1), so it needs clog2(size) bits,
    // but never fewer than one bit so SIZE=1 still has a legal vector.
    function automatic int cnt_width(input int size);
        return (size <= 1) ? 1 : $clog2(size);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : piso_tx
//  Description : Parallel-in, serial-out transmitter. Accepts a SIZE-bit word
//                on a valid/ready handshake and shifts it out one bit per
//                shift_en cycle, flagging valid bits and the last bit.
//  Ports       : clk        - system clock, posedge active
//                reset      - asynchronous clear, active low
//                din        - parallel word to transmit
//                din_valid  - din offered for transfer
//                din_ready  - a word can be accepted this cycle
//                shift_en   - bit-time enable
//                sout       - serial bit
//                sout_valid - sout carries a word bit
//                sout_last  - sout is the final bit of the word
//                busy       - a word is in flight
//  Revision    : 1.0  - initial release
// ============================================================================
module piso_tx
    import piso_pkg::*;
#(
    parameter int SIZE      = DEFAULT_SIZE,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [SIZE-1:0] din,
    input  logic            din_valid,
    output logic            din_ready,
    input  logic            shift_en,
    output logic            sout,
    output logic            sout_valid,
    output logic            sout_last,
    output logic            busy
);

    localparam int                 c_CNT_W    = cnt_width(SIZE);
    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(SIZE - 1);
    localparam int                 c_OUT_IDX  = MSB_FIRST ? SIZE - 1 : 0;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SIZE-1:0]    r_sreg;
    logic [SIZE-1:0]    w_sreg_nxt;
    logic [SIZE-1:0]    w_sreg_shifted;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_shifting;
    logic               w_last;
    logic               w_xfer;

    // Shift toward the output end with zero fill; a 1-bit word has nothing
    // left to shift, so the shifted value is simply zero.
    generate
        if (SIZE == 1) begin : g_shift_single
            assign w_sreg_shifted = '0;
        end else if (MSB_FIRST) begin : g_shift_msb
            assign w_sreg_shifted = {r_sreg[SIZE-2:0], 1'b0};
        end else begin : g_shift_lsb
            assign w_sreg_shifted = {1'b0, r_sreg[SIZE-1:1]};
        end
    endgenerate

    assign w_shifting = (r_state == SHIFT);
    assign w_last     = w_shifting && (r_cnt == '0);

    // Accepting on an enabled last bit lets words run back to back.
    assign din_ready  = (r_state == IDLE) || (w_last && shift_en);
    assign w_xfer     = din_valid && din_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_xfer) begin
                    w_state_nxt = SHIFT;
                    w_sreg_nxt  = din;
                    w_cnt_nxt   = c_CNT_LOAD;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (r_cnt != '0) begin
                        w_sreg_nxt = w_sreg_shifted;
                        w_cnt_nxt  = r_cnt - 1'b1;
                    end else if (w_xfer) begin
                        w_sreg_nxt = din;
                        w_cnt_nxt  = c_CNT_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                        w_sreg_nxt  = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_sreg_nxt  = '0;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_sreg  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // All serial outputs come from registers only; gating by state keeps
    // them at zero while idle.
    assign sout       = w_shifting && r_sreg[c_OUT_IDX];
    assign sout_valid = w_shifting;
    assign sout_last  = w_last;
    assign busy       = w_shifting;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_piso_tx
//  Description : Self-checking bench for piso_tx. Three instances
//                (SIZE=4 MSB first, SIZE=4 LSB first, SIZE=1) are compared
//                every cycle against a word/bit-position reference model.
//  Revision    : 1.0  - initial release
// ============================================================================
module tb_piso_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [3:0] dw [3];
    logic       v  [3];
    logic       se [3];
    logic       so [3];
    logic       sv [3];
    logic       sl [3];
    logic       bz [3];
    logic       rdy[3];

    logic [3:0] din0;
    logic [3:0] din1;
    logic [0:0] din2;
    assign din0 = dw[0];
    assign din1 = dw[1];
    assign din2 = dw[2][0:0];

    piso_tx #(.SIZE(4), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .din(din0), .din_valid(v[0]),
        .din_ready(rdy[0]), .shift_en(se[0]), .sout(so[0]),
        .sout_valid(sv[0]), .sout_last(sl[0]), .busy(bz[0])
    );
    piso_tx #(.SIZE(4), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .din(din1), .din_valid(v[1]),
        .din_ready(rdy[1]), .shift_en(se[1]), .sout(so[1]),
        .sout_valid(sv[1]), .sout_last(sl[1]), .busy(bz[1])
    );
    piso_tx #(.SIZE(1), .MSB_FIRST(1'b1)) u_dut2 (
        .clk(clk), .reset(reset), .din(din2), .din_valid(v[2]),
        .din_ready(rdy[2]), .shift_en(se[2]), .sout(so[2]),
        .sout_valid(sv[2]), .sout_last(sl[2]), .busy(bz[2])
    );

    // Reference model: the word in flight and how many of its bits have
    // already been sent.
    int         sz [3] = '{4, 4, 1};
    bit         msb[3] = '{1'b1, 1'b0, 1'b1};
    bit         act[3];
    logic [3:0] w  [3];
    int         pos[3];

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input int i, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s[%0d]: got %b expected %b", tag, i, obs, exp);
        end
    endtask

    function automatic logic m_bit(input int i);
        int idx;
        idx = msb[i] ? (sz[i] - 1 - pos[i]) : pos[i];
        return w[i][idx];
    endfunction

    function automatic logic m_last(input int i);
        return act[i] && (pos[i] == sz[i] - 1);
    endfunction

    function automatic logic m_ready(input int i);
        return !act[i] || (m_last(i) && se[i]);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 3; i++) begin
            act[i] = 1'b0;
            pos[i] = 0;
            w[i]   = '0;
        end
    endtask

    // Called just after a negedge with inputs already driven: check all
    // outputs, take the posedge, advance the model, return at the next negedge.
    task automatic tick();
        bit xfer[3];
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("sout_valid", i, sv[i], act[i]);
            chk("busy", i, bz[i], act[i]);
            chk("sout", i, so[i], act[i] ? m_bit(i) : 1'b0);
            chk("sout_last", i, sl[i], m_last(i));
            chk("din_ready", i, rdy[i], m_ready(i));
            xfer[i] = v[i] && m_ready(i);
        end
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            if (act[i] && se[i]) begin
                pos[i]++;
                if (pos[i] == sz[i]) act[i] = 1'b0;
            end
            if (xfer[i]) begin
                act[i] = 1'b1;
                pos[i] = 0;
                w[i]   = (sz[i] == 1) ? {3'b000, dw[i][0]} : dw[i];
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_sout", i, so[i], 1'b0);
            chk("rst_sout_valid", i, sv[i], 1'b0);
            chk("rst_sout_last", i, sl[i], 1'b0);
            chk("rst_busy", i, bz[i], 1'b0);
            chk("rst_din_ready", i, rdy[i], 1'b1);
        end
        @(posedge clk);
        @(negedge clk);
        model_clear();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dw[i] = '0;
            v[i]  = 1'b0;
            se[i] = 1'b1;
        end
        model_clear();
        @(negedge clk);
        do_reset();

        // Single MSB-first word 1011
        dw[0] = 4'b1011; v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        repeat (6) tick();

        // Back-to-back A then 5 with valid held
        dw[0] = 4'hA; v[0] = 1'b1;
        tick();
        dw[0] = 4'h5;
        repeat (4) tick();
        v[0] = 1'b0;
        repeat (6) tick();

        // shift_en gating on 1100
        dw[0] = 4'b1100; v[0] = 1'b1; se[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        for (int k = 0; k < 18; k++) begin
            se[0] = (k % 2 == 0);
            tick();
        end
        se[0] = 1'b1;

        // LSB-first word 0001
        dw[1] = 4'b0001; v[1] = 1'b1;
        tick();
        v[1] = 1'b0;
        repeat (5) tick();

        // Reset after the second bit of F
        dw[0] = 4'hF; v[0] = 1'b1;
        tick();
        v[0] = 1'b0;
        repeat (2) tick();
        do_reset();
        repeat (3) tick();

        // valid with changing din while busy: ignored until the last bit
        dw[0] = 4'h6; v[0] = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            dw[0] = 4'($urandom);
            tick();
        end
        v[0] = 1'b0;
        repeat (6) tick();

        // SIZE=1 back-to-back single-bit words
        v[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            dw[2] = 4'($urandom);
            tick();
        end
        v[2] = 1'b0;
        repeat (2) tick();

        // Randomized traffic on all instances with occasional resets
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < 3; i++) begin
                dw[i] = 4'($urandom);
                v[i]  = 1'($urandom);
                se[i] = ($urandom_range(0, 3) != 0);
            end
            if ($urandom_range(0, 63) == 0) do_reset();
            else tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
